// File: rtl/sha256_job_scheduler.sv
// Round-robin launcher sharing one SHA-256 core among NUM_REQ job sources.
// Tracks the core's idle level and reports per-owner completion or error.
module sha256_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_msg_addr,
  input  logic [16*NUM_REQ-1:0] req_out_addr,
  output logic [NUM_REQ-1:0]    cmp_valid,
  output logic                  cmp_err,
  output logic                  core_start,
  output logic [15:0]           core_msg_addr,
  output logic [15:0]           core_out_addr,
  input  logic                  core_done,
  output logic                  busy,
  output logic [15:0]           jobs_done
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WBUSY,
    S_WDONE,
    S_CMPL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] g;
  logic [GW-1:0] gidx;
  logic [GW-1:0] cand;
  logic          found;
  logic          accept;
  logic [12:0]   cnt;
  logic [12:0]   cnt_inc;
  logic          err;
  logic [15:0]   done_cnt;
  logic [15:0]   msg_arr [NUM_REQ];
  logic [15:0]   out_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign msg_arr[i] = req_msg_addr[16*i +: 16];
    assign out_arr[i] = req_out_addr[16*i +: 16];
  end

  // Search begins one past the previous owner.
  always_comb begin
    gidx  = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign accept    = (state == S_IDLE) && core_done && found;
  assign cnt_inc   = cnt + 13'd1;
  assign jobs_done = done_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WBUSY;
      S_WBUSY: begin
        if (!core_done)                       state_nxt = S_WDONE;
        else if (cnt_inc == 13'(START_WAIT))  state_nxt = S_CMPL;
      end
      S_WDONE: begin
        if (core_done)                        state_nxt = S_CMPL;
        else if (cnt_inc == 13'(TIMEOUT))     state_nxt = S_CMPL;
      end
      S_CMPL:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    cmp_valid  = '0;
    cmp_err    = 1'b0;
    core_start = (state == S_LAUNCH);
    busy       = (state != S_IDLE);
    if (accept) req_ready[gidx] = 1'b1;
    if (state == S_CMPL) begin
      cmp_valid[g] = 1'b1;
      cmp_err      = err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      err           <= 1'b0;
      g             <= '0;
      last_grant    <= GW'(NUM_REQ-1);
      core_msg_addr <= '0;
      core_out_addr <= '0;
      done_cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            g             <= gidx;
            core_msg_addr <= msg_arr[gidx];
            core_out_addr <= out_arr[gidx];
            err           <= 1'b0;
          end
        end
        S_LAUNCH: cnt <= '0;
        S_WBUSY: begin
          if (!core_done)                      cnt <= '0;
          else if (cnt_inc == 13'(START_WAIT)) err <= 1'b1;
          else                                 cnt <= cnt_inc;
        end
        S_WDONE: begin
          if (core_done)                       err <= 1'b0;
          else if (cnt_inc == 13'(TIMEOUT))    err <= 1'b1;
          else                                 cnt <= cnt_inc;
        end
        S_CMPL: begin
          if (!err) done_cnt <= done_cnt + 16'd1;
          last_grant <= g;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: behavioural core model plus an
// arbitration/latency reference derived from the job rules.
module tb_sha256_job_scheduler;

  localparam int N  = 4;
  localparam int SW = 4;
  localparam int TO = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_msg_addr = '0;
  logic [16*N-1:0] req_out_addr = '0;
  logic [N-1:0]    cmp_valid;
  logic            cmp_err;
  logic            core_start;
  logic [15:0]     core_msg_addr;
  logic [15:0]     core_out_addr;
  logic            core_done = 1'b1;
  logic            busy;
  logic [15:0]     jobs_done;

  int          core_mode = 0;
  int          core_lat  = 2;
  int          core_cnt  = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_g = N-1;
  logic [15:0] exp_jobs = '0;
  logic [15:0] ma [N];
  logic [15:0] oa [N];
  logic [N-1:0] cv;
  int          n;
  bit          bad;

  always #5 clk = ~clk;

  sha256_job_scheduler #(
    .NUM_REQ(N), .START_WAIT(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_msg_addr(req_msg_addr), .req_out_addr(req_out_addr),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err),
    .core_start(core_start),
    .core_msg_addr(core_msg_addr), .core_out_addr(core_out_addr),
    .core_done(core_done), .busy(busy), .jobs_done(jobs_done)
  );

  // Core: mode 0 runs core_lat cycles, 1 ignores start, 2 hangs busy.
  always @(posedge clk) begin
    if (core_start && core_mode != 1) begin
      core_done <= 1'b0;
      core_cnt  <= core_lat;
    end else if (!core_done && core_mode == 0) begin
      if (core_cnt <= 1) core_done <= 1'b1;
      else               core_cnt  <= core_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = m >> ((last + k) % N);
      if (t[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_bus();
    req_msg_addr = '0;
    req_out_addr = '0;
    for (int i = 0; i < N; i++) begin
      req_msg_addr |= (16*N)'(ma[i]) << (16*i);
      req_out_addr |= (16*N)'(oa[i]) << (16*i);
    end
  endtask

  // Call at a negedge with the scheduler idle and core_done high.
  task automatic do_job(input logic [N-1:0] mask, input int mode,
                        input int lat, input bit keep, input bit rnd,
                        output logic [N-1:0] owner);
    int g;
    int cyc;
    int expn;
    bit nrdy;
    logic [N-1:0] t;
    core_mode = mode;
    core_lat  = lat;
    for (int i = 0; i < N; i++) begin
      t = (mask & ~req_valid) >> i;
      if (t[0] && rnd) begin
        ma[i] = 16'($urandom);
        oa[i] = 16'($urandom);
      end
    end
    set_bus();
    req_valid = mask;
    #1;
    g = rr_pick(mask, last_g);
    chk("req_ready", 32'(req_ready), 32'(onehot(g)));
    @(negedge clk);
    chk("core_start", 32'(core_start), 32'd1);
    chk("core_msg_addr", 32'(core_msg_addr), 32'(ma[g]));
    chk("core_out_addr", 32'(core_out_addr), 32'(oa[g]));
    if (!keep) req_valid &= ~onehot(g);
    cyc  = 0;
    nrdy = 1'b0;
    while (cmp_valid == '0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) nrdy = 1'b1;
    end
    case (mode)
      0:       expn = lat + 2;
      1:       expn = SW + 1;
      default: expn = TO + 2;
    endcase
    owner = cmp_valid;
    chk("cmp_latency", 32'(cyc), 32'(expn));
    chk("cmp_valid", 32'(cmp_valid), 32'(onehot(g)));
    chk("cmp_err", 32'(cmp_err), 32'(mode != 0));
    chk("ready_while_busy", 32'(nrdy), 32'd0);
    last_g = g;
    if (mode == 0) exp_jobs++;
    @(negedge clk);
    chk("cmp_one_cycle", 32'(cmp_valid), 32'd0);
    chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      oa[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs", 32'(jobs_done), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);

    // Single directed job on requester 2.
    ma[2] = 16'h0000;
    oa[2] = 16'h0020;
    do_job(4'b0100, 0, 300, 1'b0, 1'b0, cv);

    // Reset for two cycles while the core is mid-job.
    ma[0] = 16'($urandom);
    oa[0] = 16'($urandom);
    set_bus();
    core_mode = 0;
    core_lat  = 100;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_test_launch", 32'(core_start), 32'd1);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("rst_test_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    bad   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (cmp_valid != '0) bad = 1'b1;
    end
    reset = 1'b0;
    chk("rst_no_cmp", 32'(bad), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_jobs", 32'(jobs_done), 32'd0);
    chk("rst2_start", 32'(core_start), 32'd0);
    chk("rst2_cmp", 32'(cmp_valid), 32'd0);
    chk("rst2_msg", 32'(core_msg_addr), 32'd0);
    chk("rst2_out", 32'(core_out_addr), 32'd0);
    exp_jobs = '0;
    last_g   = N-1;

    // All requesters valid; nothing granted until the core is idle.
    for (int i = 0; i < N; i++) begin
      ma[i] = 16'($urandom);
      oa[i] = 16'($urandom);
    end
    set_bus();
    req_valid = 4'hF;
    n   = 0;
    bad = 1'b0;
    while (!core_done && n < 300) begin
      #1;
      if (req_ready != '0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("no_ready_core_busy", 32'(bad), 32'd0);

    // Round robin with continuously valid requesters.
    for (int j = 0; j < 8; j++) begin
      do_job(4'hF, 0, $urandom_range(2, 20), 1'b1, 1'b1, cv);
      chk("rr_owner", 32'(cv), 32'(onehot(j % N)));
    end
    req_valid = '0;

    // Launch error: core never leaves idle.
    do_job(4'b0010, 1, 0, 1'b0, 1'b1, cv);

    // Randomized jobs.
    repeat (12) begin
      do_job(N'($urandom_range(1, 15)),
             ($urandom_range(0, 4) == 0) ? 1 : 0,
             $urandom_range(2, 30),
             1'($urandom_range(0, 1)), 1'b1, cv);
    end
    req_valid = '0;

    // Timeout: core drops done and hangs.
    do_job(4'b0100, 2, 3, 1'b0, 1'b1, cv);
    chk("timeout_core_busy", 32'(core_done), 32'd0);

    // Requester 1 withdraws; requester 3 waits for the core.
    ma[1] = 16'($urandom);
    oa[1] = 16'($urandom);
    ma[3] = 16'($urandom);
    oa[3] = 16'($urandom);
    set_bus();
    req_valid = 4'b1010;
    bad = 1'b0;
    repeat (6) begin
      #1;
      if (req_ready != '0) bad = 1'b1;
      @(negedge clk);
    end
    req_valid = 4'b1000;
    core_mode = 0;
    n = 0;
    while (!core_done && n < 50) begin
      #1;
      if (req_ready != '0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("no_accept_until_idle", 32'(bad), 32'd0);
    do_job(4'b1000, 0, 5, 1'b0, 1'b1, cv);
    chk("withdraw_owner", 32'(cv), 32'(4'b1000));

    // Success counter wrap.
    dut.done_cnt <= 16'hFFFF;
    exp_jobs = 16'hFFFF;
    @(negedge clk);
    chk("preload", 32'(jobs_done), 32'hFFFF);
    do_job(4'b0001, 0, 4, 1'b0, 1'b1, cv);
    chk("wrap", 32'(jobs_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
